// File: rtl/tmds_pkg.sv
// Shared TMDS receive definitions: control tokens, alignment FSM states and token lookup.
// With TMDS_ERR_CNT_EN defined, also provides the ones-count helper used for disparity tracking.
package tmds_pkg;

  localparam logic [9:0] TOK_C00 = 10'b1101010100;
  localparam logic [9:0] TOK_C01 = 10'b0010101011;
  localparam logic [9:0] TOK_C10 = 10'b0101010100;
  localparam logic [9:0] TOK_C11 = 10'b1010101011;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] code;
  } tok_t;

  function automatic tok_t tok_lookup(input logic [9:0] s);
    tok_t t;
    t.hit  = 1'b1;
    t.code = 2'b00;
    case (s)
      TOK_C00: t.code = 2'b00;
      TOK_C01: t.code = 2'b01;
      TOK_C10: t.code = 2'b10;
      TOK_C11: t.code = 2'b11;
      default: begin
        t.hit  = 1'b0;
        t.code = 2'b00;
      end
    endcase
    return t;
  endfunction

  function automatic logic is_token(input logic [9:0] s);
    tok_t t;
    t = tok_lookup(s);
    return t.hit;
  endfunction

`ifdef TMDS_ERR_CNT_EN
  function automatic logic [3:0] ones10(input logic [9:0] s);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 10; i++) begin
      n = n + {3'd0, s[i]};
    end
    return n;
  endfunction
`endif

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS symbol decode: 10b data symbol to pixel byte, plus control-token detect.
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [9:0] sym,
  output logic [7:0] data,
  output logic       is_tok,
  output logic [1:0] code
);

  logic [7:0] q_s;
  tok_t       tok_s;

  // Undo the optional inversion, then the XOR/XNOR transition chain
  always_comb begin
    q_s     = sym[9] ? ~sym[7:0] : sym[7:0];
    data    = 8'h00;
    data[0] = q_s[0];
    for (int i = 1; i < 8; i++) begin
      data[i] = sym[8] ? (q_s[i] ^ q_s[i-1]) : ~(q_s[i] ^ q_s[i-1]);
    end
    tok_s  = tok_lookup(sym);
    is_tok = tok_s.hit;
    code   = tok_s.code;
  end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: word alignment on control tokens, then 2-stage decode to de/ctrl/data.
// Define TMDS_ERR_CNT_EN to build the running-disparity violation counter and its err_count port.
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int CTRL_RUN_MIN = 8,
  parameter int LOCK_TIMEOUT = 4096
`ifdef TMDS_ERR_CNT_EN
  , parameter int DISP_LIMIT = 16
`endif
) (
  input  logic        clk_low,
  input  logic        reset,
  input  logic [9:0]  raw_in,
  output logic [7:0]  data_out,
  output logic [1:0]  ctrl_out,
  output logic        de_out,
  output logic        locked,
  output logic [3:0]  offset_out
`ifdef TMDS_ERR_CNT_EN
  , output logic [15:0] err_count
`endif
);

  localparam int RUN_W = $clog2(CTRL_RUN_MIN + 1);
  localparam int TMR_W = $clog2(LOCK_TIMEOUT);

  logic [9:0]       raw_q_r;
  logic [19:0]      win_s;
  logic [9:0]       sym_s;
  logic             sym_hit_s;
  logic [9:0]       tok_hit_s;
  logic             match_found_s;
  logic [3:0]       match_off_s;
  state_t           state_r, state_nxt_s;
  logic [3:0]       offset_r, offset_nxt_s;
  logic [RUN_W-1:0] run_cnt_r, run_cnt_nxt_s;
  logic [TMR_W-1:0] blank_tmr_r, blank_tmr_nxt_s;
  logic [9:0]       sym_q_r;
  logic             lock_s1_r;
  logic [7:0]       dec_data_s;
  logic             dec_tok_s;
  logic [1:0]       dec_code_s;
  logic [1:0]       last_code_r;

  assign win_s      = {raw_in, raw_q_r};
  assign sym_s      = 10'(win_s >> offset_r);
  assign sym_hit_s  = is_token(sym_s);
  assign offset_out = offset_r;

  // Test every bit offset in parallel; the lowest matching offset wins
  always_comb begin
    tok_hit_s   = 10'd0;
    match_off_s = 4'd0;
    for (int i = 0; i < 10; i++) begin
      tok_hit_s[i] = is_token(10'(win_s >> i));
    end
    match_found_s = |tok_hit_s;
    for (int i = 9; i >= 0; i--) begin
      match_off_s = tok_hit_s[i] ? 4'(i) : match_off_s;
    end
  end

  // Alignment FSM next-state logic
  always_comb begin
    state_nxt_s     = state_r;
    offset_nxt_s    = offset_r;
    run_cnt_nxt_s   = run_cnt_r;
    blank_tmr_nxt_s = blank_tmr_r;
    case (state_r)
      ST_SEARCH: begin
        if (match_found_s) begin
          offset_nxt_s  = match_off_s;
          run_cnt_nxt_s = RUN_W'(1);
          state_nxt_s   = ST_VERIFY;
        end else begin
          run_cnt_nxt_s = RUN_W'(0);
        end
      end
      ST_VERIFY: begin
        if (!sym_hit_s) begin
          run_cnt_nxt_s = RUN_W'(0);
          state_nxt_s   = ST_SEARCH;
        end else if (run_cnt_r == RUN_W'(CTRL_RUN_MIN - 1)) begin
          run_cnt_nxt_s   = RUN_W'(0);
          blank_tmr_nxt_s = TMR_W'(0);
          state_nxt_s     = ST_LOCKED;
        end else begin
          run_cnt_nxt_s = run_cnt_r + RUN_W'(1);
        end
      end
      ST_LOCKED: begin
        // A token on the timeout cycle still keeps the lock
        if (sym_hit_s) begin
          blank_tmr_nxt_s = TMR_W'(0);
        end else if (blank_tmr_r == TMR_W'(LOCK_TIMEOUT - 1)) begin
          blank_tmr_nxt_s = TMR_W'(0);
          state_nxt_s     = ST_SEARCH;
        end else begin
          blank_tmr_nxt_s = blank_tmr_r + TMR_W'(1);
        end
      end
      default: begin
        state_nxt_s     = ST_SEARCH;
        offset_nxt_s    = 4'd0;
        run_cnt_nxt_s   = RUN_W'(0);
        blank_tmr_nxt_s = TMR_W'(0);
      end
    endcase
  end

  // FSM state, input history and stage-1 symbol registers
  always_ff @(posedge clk_low) begin
    if (reset) begin
      state_r     <= ST_SEARCH;
      offset_r    <= 4'd0;
      run_cnt_r   <= RUN_W'(0);
      blank_tmr_r <= TMR_W'(0);
      raw_q_r     <= 10'd0;
      sym_q_r     <= 10'd0;
      lock_s1_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      offset_r    <= offset_nxt_s;
      run_cnt_r   <= run_cnt_nxt_s;
      blank_tmr_r <= blank_tmr_nxt_s;
      raw_q_r     <= raw_in;
      sym_q_r     <= sym_s;
      lock_s1_r   <= (state_nxt_s == ST_LOCKED);
    end
  end

  tmds_symbol_decode u_dec (
    .sym    (sym_q_r),
    .data   (dec_data_s),
    .is_tok (dec_tok_s),
    .code   (dec_code_s)
  );

  // Stage-2 output registers, forced quiet unless the aligned lock flag is set
  always_ff @(posedge clk_low) begin
    if (reset) begin
      data_out    <= 8'h00;
      ctrl_out    <= 2'b00;
      de_out      <= 1'b0;
      locked      <= 1'b0;
      last_code_r <= 2'b00;
    end else begin
      locked      <= lock_s1_r;
      last_code_r <= dec_tok_s ? dec_code_s : last_code_r;
      if (lock_s1_r && dec_tok_s) begin
        data_out <= 8'h00;
        ctrl_out <= dec_code_s;
        de_out   <= 1'b0;
      end else if (lock_s1_r) begin
        data_out <= dec_data_s;
        ctrl_out <= last_code_r;
        de_out   <= 1'b1;
      end else begin
        data_out <= 8'h00;
        ctrl_out <= 2'b00;
        de_out   <= 1'b0;
      end
    end
  end

`ifdef TMDS_ERR_CNT_EN
  logic signed [5:0] rd_r;
  logic signed [5:0] rd_sum_s;
  logic [5:0]        rd_abs_s;
  logic              rd_over_s;

  // Headroom: |rd| is cleared once above the limit, so it never exceeds limit + 10
  assign rd_sum_s  = rd_r + $signed({1'b0, ones10(sym_q_r), 1'b0}) - 6'sd10;
  assign rd_abs_s  = rd_r[5] ? 6'(-rd_r) : 6'(rd_r);
  assign rd_over_s = (rd_abs_s > 6'(DISP_LIMIT));

  // Running disparity over data symbols and saturating violation count
  always_ff @(posedge clk_low) begin
    if (reset) begin
      rd_r      <= 6'sd0;
      err_count <= 16'h0000;
    end else begin
      rd_r <= (dec_tok_s || rd_over_s) ? 6'sd0 : rd_sum_s;
      if (rd_over_s && (state_r == ST_LOCKED) && (err_count != 16'hFFFF)) begin
        err_count <= err_count + 16'h0001;
      end else begin
        err_count <= err_count;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Scoreboard bench for tmds_channel_decoder: builds serial bit streams, models expected outputs per word.
module tb_tmds_channel_decoder;

  logic       clk_low = 1'b0;
  logic       reset   = 1'b1;
  logic [9:0] raw_in  = 10'd0;
  logic [7:0] data_out;
  logic [1:0] ctrl_out;
  logic       de_out;
  logic       locked;
  logic [3:0] offset_out;
`ifdef TMDS_ERR_CNT_EN
  logic [15:0] err_count;
`endif

  tmds_channel_decoder dut (
    .clk_low    (clk_low),
    .reset      (reset),
    .raw_in     (raw_in),
    .data_out   (data_out),
    .ctrl_out   (ctrl_out),
    .de_out     (de_out),
    .locked     (locked),
    .offset_out (offset_out)
`ifdef TMDS_ERR_CNT_EN
    , .err_count (err_count)
`endif
  );

  always #5 clk_low = ~clk_low;

  localparam logic [9:0] C00 = 10'b1101010100;
  localparam logic [9:0] C01 = 10'b0010101011;
  localparam logic [9:0] C10 = 10'b0101010100;
  localparam logic [9:0] C11 = 10'b1010101011;
  localparam logic [9:0] D1  = 10'b0100000000;
  localparam logic [9:0] D2  = 10'b1111111110;

  typedef struct {
    bit         chk;
    logic       lk;
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  exp_t       plan[$];
  bit         bits_q[$];
  logic [9:0] syms[$];
  bit         slk[$];
  int         total = 0;
  int         bad   = 0;

  function automatic logic [2:0] ref_tok(input logic [9:0] s);
    if (s == C00) return 3'b100;
    if (s == C01) return 3'b101;
    if (s == C10) return 3'b110;
    if (s == C11) return 3'b111;
    return 3'b000;
  endfunction

  function automatic logic [7:0] ref_decode(input logic [9:0] s);
    logic [7:0] q;
    logic [7:0] d;
    q = s[9] ? ~s[7:0] : s[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

  function automatic logic [9:0] get_word(input int n);
    logic [9:0] w;
    w = 10'd0;
    for (int b = 0; b < 10; b++) begin
      if (10 * n + b < bits_q.size()) w[b] = bits_q[10 * n + b];
    end
    return w;
  endfunction

  task automatic clear_stream();
    bits_q.delete();
    syms.delete();
    slk.delete();
  endtask

  task automatic add_gap(input int n);
    for (int i = 0; i < n; i++) bits_q.push_back(1'b0);
  endtask

  task automatic add_sym(input logic [9:0] s, input bit lk);
    for (int b = 0; b < 10; b++) bits_q.push_back(s[b]);
    syms.push_back(s);
    slk.push_back(lk);
  endtask

  // Word n completes symbol n-1; word 0 completes nothing; a trailing flush entry is unchecked
  task automatic build_plan();
    exp_t       e;
    logic [1:0] lc;
    logic [2:0] t;
    plan.delete();
    lc = 2'b00;
    e = '{chk: 1'b1, lk: 1'b0, de: 1'b0, ctrl: 2'b00, data: 8'h00};
    plan.push_back(e);
    for (int j = 0; j < syms.size(); j++) begin
      t = ref_tok(syms[j]);
      e = '{chk: 1'b1, lk: 1'b0, de: 1'b0, ctrl: 2'b00, data: 8'h00};
      if (slk[j]) begin
        e.lk = 1'b1;
        if (t[2]) begin
          e.ctrl = t[1:0];
        end else begin
          e.de   = 1'b1;
          e.ctrl = lc;
          e.data = ref_decode(syms[j]);
        end
      end
      if (t[2]) lc = t[1:0];
      plan.push_back(e);
    end
    e = '{chk: 1'b0, lk: 1'b0, de: 1'b0, ctrl: 2'b00, data: 8'h00};
    plan.push_back(e);
  endtask

  task automatic step(input logic [9:0] w, input exp_t e, output exp_t due);
    raw_in = w;
    sb.push_back(e);
    @(posedge clk_low);
    #1;
    due = sb.pop_front();
  endtask

  task automatic do_reset();
    exp_t z;
    reset  = 1'b1;
    raw_in = 10'd0;
    repeat (2) @(posedge clk_low);
    #1;
    reset = 1'b0;
    sb.delete();
    z = '{chk: 1'b1, lk: 1'b0, de: 1'b0, ctrl: 2'b00, data: 8'h00};
    sb.push_back(z);
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    raw_in = 10'h3FF;
    repeat (2) @(posedge clk_low);
    #1;
    total++;
    if ({locked, de_out, ctrl_out, data_out, offset_out} !== 16'h0000) begin
      bad++;
      $display("FAIL reset_state got lk=%b de=%b ctrl=%b data=%h off=%0d want all 0",
               locked, de_out, ctrl_out, data_out, offset_out);
    end
`ifdef TMDS_ERR_CNT_EN
    total++;
    if (err_count !== 16'h0000) begin
      bad++;
      $display("FAIL reset_err got %0d want 0", err_count);
    end
`endif
  endtask

  task automatic test_lock_offset3();
    exp_t due;
    do_reset();
    clear_stream();
    add_gap(3);
    for (int k = 0; k < 20; k++) add_sym(C00, k >= 7);
    add_sym(D1, 1'b1);
    for (int k = 0; k < 3; k++) add_sym(C00, 1'b1);
    build_plan();
    for (int n = 0; n < plan.size(); n++) begin
      step(get_word(n), plan[n], due);
      if (due.chk) begin
        total++;
        if ({locked, de_out, ctrl_out, data_out} !== {due.lk, due.de, due.ctrl, due.data}) begin
          bad++;
          $display("FAIL lock3 word=%0d got lk=%b de=%b ctrl=%b data=%h want lk=%b de=%b ctrl=%b data=%h",
                   n - 1, locked, de_out, ctrl_out, data_out, due.lk, due.de, due.ctrl, due.data);
        end
      end
    end
    total++;
    if (offset_out !== 4'd3 || locked !== 1'b1) begin
      bad++;
      $display("FAIL lock3_offset got off=%0d lk=%b want off=3 lk=1", offset_out, locked);
    end
  endtask

  task automatic test_ctrl_codes();
    exp_t due;
    do_reset();
    clear_stream();
    add_gap(3);
    for (int k = 0; k < 10; k++) add_sym(C00, k >= 7);
    add_sym(C11, 1'b1);
    add_sym(C11, 1'b1);
    add_sym(D2, 1'b1);
    add_sym(C11, 1'b1);
    add_sym(D1, 1'b1);
    add_sym(C00, 1'b1);
    add_sym(D2, 1'b1);
    build_plan();
    for (int n = 0; n < plan.size(); n++) begin
      step(get_word(n), plan[n], due);
      if (due.chk) begin
        total++;
        if ({locked, de_out, ctrl_out, data_out} !== {due.lk, due.de, due.ctrl, due.data}) begin
          bad++;
          $display("FAIL ctrl word=%0d got lk=%b de=%b ctrl=%b data=%h want lk=%b de=%b ctrl=%b data=%h",
                   n - 1, locked, de_out, ctrl_out, data_out, due.lk, due.de, due.ctrl, due.data);
        end
      end
    end
  endtask

  task automatic test_relock_offset7();
    exp_t due;
    do_reset();
    clear_stream();
    add_gap(3);
    for (int k = 0; k < 5; k++) add_sym(C00, 1'b0);
    add_sym(D1, 1'b0);
    add_gap(4);
    for (int k = 0; k < 8; k++) add_sym(C00, k == 7);
    add_sym(C00, 1'b1);
    add_sym(C00, 1'b1);
    build_plan();
    for (int n = 0; n < plan.size(); n++) begin
      step(get_word(n), plan[n], due);
      if (due.chk) begin
        total++;
        if ({locked, de_out, ctrl_out, data_out} !== {due.lk, due.de, due.ctrl, due.data}) begin
          bad++;
          $display("FAIL relock word=%0d got lk=%b de=%b ctrl=%b data=%h want lk=%b de=%b ctrl=%b data=%h",
                   n - 1, locked, de_out, ctrl_out, data_out, due.lk, due.de, due.ctrl, due.data);
        end
      end
    end
    total++;
    if (offset_out !== 4'd7 || locked !== 1'b1) begin
      bad++;
      $display("FAIL relock_offset got off=%0d lk=%b want off=7 lk=1", offset_out, locked);
    end
  endtask

  task automatic test_timeout();
    exp_t due;
    do_reset();
    clear_stream();
    add_gap(3);
    for (int k = 0; k < 10; k++) add_sym(C00, k >= 7);
    for (int m = 1; m <= 4100; m++) add_sym(D1, m < 4096);
    build_plan();
    for (int n = 0; n < plan.size(); n++) begin
      step(get_word(n), plan[n], due);
      if (due.chk) begin
        total++;
        if ({locked, de_out, ctrl_out, data_out} !== {due.lk, due.de, due.ctrl, due.data}) begin
          bad++;
          $display("FAIL timeout word=%0d got lk=%b de=%b ctrl=%b data=%h want lk=%b de=%b ctrl=%b data=%h",
                   n - 1, locked, de_out, ctrl_out, data_out, due.lk, due.de, due.ctrl, due.data);
        end
      end
    end
  endtask

  task automatic test_reset_midlock();
    exp_t due;
    do_reset();
    clear_stream();
    add_gap(3);
    for (int k = 0; k < 12; k++) add_sym(C00, k >= 7);
    build_plan();
    for (int n = 0; n < plan.size(); n++) begin
      step(get_word(n), plan[n], due);
      if (due.chk) begin
        total++;
        if ({locked, de_out, ctrl_out, data_out} !== {due.lk, due.de, due.ctrl, due.data}) begin
          bad++;
          $display("FAIL midlock_pre word=%0d got lk=%b want lk=%b", n - 1, locked, due.lk);
        end
      end
    end
    total++;
    if (locked !== 1'b1 || offset_out !== 4'd3) begin
      bad++;
      $display("FAIL midlock_locked got lk=%b off=%0d want lk=1 off=3", locked, offset_out);
    end
    reset  = 1'b1;
    raw_in = C00;
    @(posedge clk_low);
    #1;
    total++;
    if ({locked, de_out, ctrl_out, data_out, offset_out} !== 16'h0000) begin
      bad++;
      $display("FAIL midlock_reset got lk=%b de=%b ctrl=%b data=%h off=%0d want all 0",
               locked, de_out, ctrl_out, data_out, offset_out);
    end
    reset = 1'b0;
  endtask

`ifdef TMDS_ERR_CNT_EN
  task automatic test_err_count();
    exp_t due;
    do_reset();
    clear_stream();
    add_gap(3);
    for (int k = 0; k < 10; k++) add_sym(C00, k >= 7);
    for (int k = 0; k < 3; k++) add_sym(D2, 1'b1);
    for (int k = 0; k < 3; k++) add_sym(C00, 1'b1);
    build_plan();
    for (int n = 0; n < plan.size(); n++) begin
      step(get_word(n), plan[n], due);
      if (due.chk) begin
        total++;
        if ({locked, de_out, ctrl_out, data_out} !== {due.lk, due.de, due.ctrl, due.data}) begin
          bad++;
          $display("FAIL errcnt_stream word=%0d got lk=%b de=%b want lk=%b de=%b",
                   n - 1, locked, de_out, due.lk, due.de);
        end
      end
    end
    total++;
    if (err_count !== 16'd1) begin
      bad++;
      $display("FAIL err_count got %0d want 1", err_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_lock_offset3();
    test_ctrl_codes();
    test_relock_offset7();
    test_timeout();
    test_reset_midlock();
`ifdef TMDS_ERR_CNT_EN
    test_err_count();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
